// File: rtl/generador_pulsos_corriente.sv
// Pushbutton front end for the current-setpoint counter.
// Two raw buttons are synchronized and debounced, then a small FSM turns the
// debounced levels into single-cycle up/down command pulses, with auto-repeat
// while a button is held and a lockout when both buttons are pressed.

// Per-button debouncer: the level follows the input only after it has
// disagreed for DEB_CYCLES consecutive cycles.
module gpc_debounce #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 26
) (
  input  logic clkp,
  input  logic resetp,
  input  logic s_i,
  output logic d_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_q, d_d;

  // Count disagreeing cycles; any agreeing cycle restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    d_d   = d_q;
    if (s_i != d_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        d_d   = s_i;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clkp or posedge resetp) begin
    if (resetp) begin
      cnt_q <= '0;
      d_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      d_q   <= d_d;
    end
  end

  assign d_o = d_q;

endmodule

module generador_pulsos_corriente #(
  parameter int DEB_CYCLES    = 1000000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 20000000,
  parameter int CNT_W         = 26
) (
  input  logic clkp,
  input  logic resetp,
  input  logic btn_upp,
  input  logic btn_downp,
  output logic enp,
  output logic upp,
  output logic downp
);

  localparam int NUM_BTN = 2;
  localparam int B_UP    = 0;
  localparam int B_DN    = 1;

  typedef enum logic [1:0] {IDLE, WAIT_HOLD, REPEAT, LOCKOUT} state_e;
  typedef enum logic {DIR_UP, DIR_DN} dir_e;

  logic [NUM_BTN-1:0] raw, sync1_q, sync2_q, deb;

  assign raw = {btn_downp, btn_upp};

  // Two-flop synchronizer for both raw buttons.
  always_ff @(posedge clkp or posedge resetp) begin
    if (resetp) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    gpc_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_deb (
      .clkp   (clkp),
      .resetp (resetp),
      .s_i    (sync2_q[i]),
      .d_o    (deb[i])
    );
  end

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [CNT_W-1:0] t_q, t_d, t_lim;
  logic             up_q, up_d, dn_q, dn_d, en_q, en_d;
  logic             act, opp;

  // Level of the button that started the current hold, and of the other one.
  assign act = (dir_q == DIR_UP) ? deb[B_UP] : deb[B_DN];
  assign opp = (dir_q == DIR_UP) ? deb[B_DN] : deb[B_UP];

  // Next-state logic; release and opposite-press win over a timer match.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    t_d     = t_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    t_lim   = (state_q == WAIT_HOLD) ? CNT_W'(HOLD_CYCLES - 1)
                                     : CNT_W'(REPEAT_CYCLES - 1);
    case (state_q)
      IDLE: begin
        case ({deb[B_DN], deb[B_UP]})
          2'b01: begin
            up_d    = 1'b1;
            dir_d   = DIR_UP;
            t_d     = '0;
            state_d = WAIT_HOLD;
          end
          2'b10: begin
            dn_d    = 1'b1;
            dir_d   = DIR_DN;
            t_d     = '0;
            state_d = WAIT_HOLD;
          end
          2'b11:   state_d = LOCKOUT;
          default: state_d = IDLE;
        endcase
      end
      WAIT_HOLD, REPEAT: begin
        if (!act) begin
          state_d = IDLE;
        end else if (opp) begin
          state_d = LOCKOUT;
        end else if (t_q == t_lim) begin
          up_d    = (dir_q == DIR_UP);
          dn_d    = (dir_q == DIR_DN);
          t_d     = '0;
          state_d = REPEAT;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      LOCKOUT: begin
        if (deb == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    en_d = up_d | dn_d;
  end

  // FSM state, hold timer and registered command outputs.
  always_ff @(posedge clkp or posedge resetp) begin
    if (resetp) begin
      state_q <= IDLE;
      dir_q   <= DIR_UP;
      t_q     <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      t_q     <= t_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      en_q    <= en_d;
    end
  end

  assign upp   = up_q;
  assign downp = dn_q;
  assign enp   = en_q;

endmodule

// File: tb/tb_generador_pulsos_corriente.sv
// Bench for generador_pulsos_corriente: directed scenarios plus random button
// traffic, every cycle compared against a timestamp-based reference model.
module tb_generador_pulsos_corriente;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 5;
  localparam int MAXE = 16384;

  logic clkp = 1'b0, resetp = 1'b1, btn_upp = 1'b0, btn_downp = 1'b0;
  logic enp, upp, downp;

  generador_pulsos_corriente #(
    .DEB_CYCLES    (DEB),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP),
    .CNT_W         (26)
  ) dut (
    .clkp      (clkp),
    .resetp    (resetp),
    .btn_upp   (btn_upp),
    .btn_downp (btn_downp),
    .enp       (enp),
    .upp       (upp),
    .downp     (downp)
  );

  always #5 clkp = ~clkp;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: raw history indexed by edge number, debounce as
  // "DEB consecutive disagreeing edges since the streak started", FSM as
  // modes with the absolute edge at which the next repeat is due.
  bit rh [2][MAXE];
  int e = 0, base = 0;
  bit md [2];
  int run0 [2];
  int mode = 0;          // 0 idle, 1 hold, 2 repeat, 3 lockout
  int mdir = 0;          // 0 up, 1 down
  int due = 0;
  bit m_up = 0, m_dn = 0;

  function automatic bit s_at(int b, int m);
    return (m - 2 >= base + 1) ? rh[b][m-2] : 1'b0;
  endfunction

  initial begin
    forever begin
      @(posedge clkp or posedge resetp);
      if (resetp) begin
        base = e; md[0] = 0; md[1] = 0; run0[0] = 0; run0[1] = 0;
        mode = 0; mdir = 0; m_up = 0; m_dn = 0;
      end else begin
        e++;
        rh[0][e] = btn_upp;
        rh[1][e] = btn_downp;
        m_up = 0; m_dn = 0;
        case (mode)
          0: begin
            if (md[0] && !md[1]) begin m_up = 1; mdir = 0; due = e + HOLD; mode = 1; end
            else if (md[1] && !md[0]) begin m_dn = 1; mdir = 1; due = e + HOLD; mode = 1; end
            else if (md[0] && md[1]) mode = 3;
          end
          1, 2: begin
            if (!md[mdir]) mode = 0;
            else if (md[1-mdir]) mode = 3;
            else if (e == due) begin
              if (mdir == 0) m_up = 1; else m_dn = 1;
              due = e + REP; mode = 2;
            end
          end
          default: if (!md[0] && !md[1]) mode = 0;
        endcase
        for (int b = 0; b < 2; b++) begin
          if (s_at(b, e) != md[b]) begin
            if (run0[b] == 0) run0[b] = e;
            if (e - run0[b] + 1 == DEB) begin md[b] = s_at(b, e); run0[b] = 0; end
          end else begin
            run0[b] = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison and pulse bookkeeping (behavioural counter 0..20).
  bit chk_en = 0;
  int up_cnt = 0, dn_cnt = 0, tb_cnt = 0;
  initial begin
    forever begin
      @(negedge clkp);
      if (chk_en) begin
        chk("upp", upp, m_up);
        chk("downp", downp, m_dn);
        chk("enp", enp, m_up | m_dn);
        chk("excl", upp & downp, 0);
      end
      if (upp) begin up_cnt++; tb_cnt = (tb_cnt == 20) ? 0 : tb_cnt + 1; end
      if (downp) begin dn_cnt++; tb_cnt = (tb_cnt == 0) ? 20 : tb_cnt - 1; end
    end
  end

  task automatic cyc(input logic u, input logic d, input int n);
    btn_upp = u;
    btn_downp = d;
    repeat (n) @(negedge clkp);
  endtask

  task automatic clr();
    up_cnt = 0; dn_cnt = 0;
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clkp);
    chk("rst_enp", enp, 0);
    chk("rst_upp", upp, 0);
    chk("rst_downp", downp, 0);
    resetp = 1'b0;
    chk_en = 1;
    cyc(0, 0, 5);

    // Glitch shorter than the debounce window.
    clr(); cyc(0, 1, 3); cyc(0, 0, 20);
    chk("glitch", dn_cnt, 0);
    // Press long enough to debounce, released before the hold delay.
    clr(); cyc(0, 1, 10); cyc(0, 0, 20);
    chk("down_one", dn_cnt, 1);
    // Auto-repeat: pulses at relative 0,10,15,20,25,30,35.
    clr(); cyc(1, 0, 40); cyc(0, 0, 20);
    chk("repeat_cnt", up_cnt, 7);
    chk("repeat_dn", dn_cnt, 0);
    // Both pressed together, then up released, then both, then down alone.
    clr(); cyc(1, 1, 20); cyc(0, 1, 20); cyc(0, 0, 20);
    chk("both_cnt", up_cnt + dn_cnt, 0);
    cyc(0, 1, 8); cyc(0, 0, 20);
    chk("after_both", dn_cnt, 1);
    // Opposite press during hold.
    clr(); cyc(1, 0, 9); cyc(1, 1, 30); cyc(0, 0, 20);
    chk("opp_up", up_cnt, 1);
    chk("opp_dn", dn_cnt, 0);

    // Counter integration: 22 single up presses from 0, wrapping past 20.
    tb_cnt = 0;
    for (int i = 1; i <= 22; i++) begin
      cyc(1, 0, 6); cyc(0, 0, 8);
      if (i == 21) chk("cnt_wrap", tb_cnt, 0);
    end
    chk("cnt_after", tb_cnt, 1);

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 200; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 25));
    cyc(0, 0, 30);

    // Reset mid-hold, button kept held through and after reset.
    cyc(1, 0, 15);
    @(posedge clkp);
    #3 resetp = 1'b1;
    #1;
    chk("arst_enp", enp, 0);
    chk("arst_upp", upp, 0);
    chk("arst_downp", downp, 0);
    repeat (3) @(negedge clkp);
    resetp = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clkp); #1;
      if (upp) lat = i;
    end
    chk("rst_lat", lat, 7);
    @(posedge clkp); #1;
    chk("rst_enp_w", enp, 0);
    @(negedge clkp);
    cyc(0, 0, 30);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
